// File: rtl/kernel_stream_pack_sink_pkg.sv
// Shared types and defaults for the kernel output stream packer.
package kernel_stream_pack_sink_pkg;

    localparam int STREAMW_DEF = 32;
    localparam int NLANES_DEF  = 4;
    localparam int CNTW_DEF    = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2,
        DONE    = 2'd3
    } state_e;

    // A single-lane build still needs a 1-bit lane index.
    function automatic int lane_w(input int nlanes);
        return (nlanes > 1) ? $clog2(nlanes) : 1;
    endfunction

    localparam int LANEW_DEF = lane_w(NLANES_DEF);

endpackage

// File: rtl/kernel_stream_outreg.sv
// Single-entry valid/ready output register; loads on load_i, drains on m_ready_i.
// Load and drain in the same cycle are allowed, so out_free_o is high when empty or draining.
module kernel_stream_outreg #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    output logic         out_free_o,
    output logic         m_valid_o,
    input  logic         m_ready_i,
    output logic [W-1:0] m_data_o,
    output logic         m_last_o
);

    logic         vld_q;
    logic [W-1:0] data_q;
    logic         last_q;

    assign out_free_o = !vld_q || m_ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
        end else if (load_i) begin
            vld_q  <= 1'b1;
            data_q <= data_i;
            last_q <= last_i;
        end else if (m_ready_i) begin
            vld_q  <= 1'b0;
        end
    end

    assign m_valid_o = vld_q;
    assign m_data_o  = data_q;
    assign m_last_o  = last_q;

endmodule

// File: rtl/kernel_stream_pack_sink.sv
// Receives a counted scalar stream from a kernel and packs it into NLANES-wide words.
// Completing element accepted in cycle N gives m_valid in N+1; sustains 1 element/cycle.
module kernel_stream_pack_sink
    import kernel_stream_pack_sink_pkg::*;
#(
    parameter int STREAMW = STREAMW_DEF,
    parameter int NLANES  = NLANES_DEF,
    parameter int CNTW    = CNTW_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CNTW-1:0]           nelems,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [STREAMW-1:0]        s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [NLANES*STREAMW-1:0] m_data,
    output logic                      m_last,
    output logic                      busy,
    output logic                      done
);

    localparam int LW = lane_w(NLANES);
    localparam int PW = NLANES * STREAMW;

    state_e          state_q, state_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [CNTW-1:0] rem_q, rem_d;
    logic [PW-1:0]   pack_q, pack_d;

    logic          completing;
    logic          out_free;
    logic          s_acc;
    logic          load;
    logic [PW-1:0] word;

    assign completing = (lane_q == LW'(NLANES - 1)) || (rem_q == CNTW'(1));
    assign s_ready    = (state_q == COLLECT) && (rem_q != '0) && (!completing || out_free);
    assign s_acc      = s_valid && s_ready;
    assign load       = s_acc && completing;

    // The word handed to the output register must include this cycle's element.
    always_comb begin
        word = pack_q;
        word[lane_q*STREAMW +: STREAMW] = s_data;
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        rem_d   = rem_q;
        pack_d  = pack_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (nelems != '0) begin
                        state_d = COLLECT;
                        rem_d   = nelems;
                        lane_d  = '0;
                        pack_d  = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            COLLECT: begin
                if (s_acc) begin
                    rem_d = rem_q - CNTW'(1);
                    if (completing) begin
                        lane_d = '0;
                        pack_d = '0;
                        if (rem_q == CNTW'(1)) begin
                            state_d = FLUSH;
                        end
                    end else begin
                        lane_d = lane_q + LW'(1);
                        pack_d = word;
                    end
                end
            end
            FLUSH: begin
                if (m_valid && m_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            rem_q   <= '0;
            pack_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            rem_q   <= rem_d;
            pack_q  <= pack_d;
        end
    end

    kernel_stream_outreg #(
        .W (PW)
    ) u_outreg (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .data_i     (word),
        .last_i     (rem_q == CNTW'(1)),
        .out_free_o (out_free),
        .m_valid_o  (m_valid),
        .m_ready_i  (m_ready),
        .m_data_o   (m_data),
        .m_last_o   (m_last)
    );

    assign busy = (state_q == COLLECT) || (state_q == FLUSH);
    assign done = (state_q == DONE);

endmodule
